// File: rtl/min_max_tracker.sv
// Per-frame unsigned min/max/count tracker over valid/ready; result one cycle after the last sample.
// Holds the result until out_ready, refusing new samples meanwhile (one bubble per frame at best).
module min_max_tracker #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_min,
    output logic [WIDTH-1:0]     out_max,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] state;
    logic       in_fire;
    logic       out_fire;
    logic       cnt_full;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign cnt_full  = (out_count == {CNT_WIDTH{1'b1}});

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        out_min   <= in_data;
                        out_max   <= in_data;
                        out_count <= CNT_WIDTH'(1);
                        out_sat   <= 1'b0;
                        state     <= in_last ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        if (in_data < out_min) out_min <= in_data;
                        if (in_data > out_max) out_max <= in_data;
                        // Counter pins at all-ones; sat remembers the overflow until the next frame.
                        if (cnt_full) out_sat <= 1'b1;
                        else          out_count <= out_count + CNT_WIDTH'(1);
                        if (in_last) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/min_max_tracker.md
# min_max_tracker

Streaming extremum tracker that consumes unsigned WIDTH-bit samples over a valid/ready handshake. Each sample is compared against the running minimum and maximum, and samples are counted until a frame ends on `in_last`. The frame result (min, max, count, saturation flag) is then presented on a second valid/ready handshake. It sits downstream of the datapath library's magnitude-compare function as its consumer: it turns per-pair lt/eq/gt decisions into per-frame statistics.

## Interface
- `WIDTH`, 8: sample width in bits; comparison is unsigned.
- `CNT_WIDTH`, 8: width of the per-frame sample counter.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  tracker can accept a sample.
- `in_data`  in  WIDTH  sample value.
- `in_last`  in  1  sample is the final one of its frame.
- `out_valid`  out  1  frame result is presented.
- `out_ready`  in  1  downstream accepts the result.
- `out_min`  out  WIDTH  smallest sample of the frame.
- `out_max`  out  WIDTH  largest sample of the frame.
- `out_count`  out  CNT_WIDTH  number of samples in the frame (saturating).
- `out_sat`  out  1  frame length exceeded 2^CNT_WIDTH-1.

## Operation
- **State machine:** three states.
  - `IDLE`: no sample of the current frame has been accepted yet.
  - `ACC`: a frame is in progress.
  - `HOLD`: the result is being presented.
- **Handshake signals:**
  - `in_ready` = (state != `HOLD`). It is combinational from the state register.
  - `out_valid` = (state == `HOLD`).
  - A sample is accepted when `in_valid && in_ready` at a rising edge.
  - A result is accepted when `out_valid && out_ready`.
- **Accept in `IDLE`:**
  - min and max are both loaded with `in_data`; count = 1; sat = 0.
  - Next state is `HOLD` if `in_last`, otherwise `ACC`.
- **Accept in `ACC`:**
  - If `in_data` < min, min is loaded with `in_data`.
  - If `in_data` > max, max is loaded with `in_data`.
  - Equal values leave the registers unchanged.
  - count increments. At all-ones it holds and sat is set to 1, staying set until the next frame starts.
  - Next state is `HOLD` if `in_last`, otherwise stay in `ACC`.
- **No sample is accepted in `ACC` or `IDLE`:** all registers hold.
- **`HOLD`:**
  - `out_min`, `out_max`, `out_count` and `out_sat` stay stable and are not updated.
  - On `out_ready`, next state is `IDLE`. The registers keep their values, and the next accepted sample overwrites them.
- **Output meaning:** `out_min`, `out_max`, `out_count` and `out_sat` are direct register outputs. They are meaningful only while `out_valid` = 1 and are don't-care at other times.
- **Unsigned only:** sample 8'hFF is larger than 8'h00.

## Timing
- **Reset (`Rst_n` = 0, asynchronous):**
  - State goes to `IDLE`.
  - `out_min`, `out_max`, `out_count` and `out_sat` go to 0.
  - `out_valid` = 0 and `in_ready` = 1, including while reset is held.
- **Latency:** if the last sample is accepted at edge N, `out_valid` is 1 from edge N through the edge at which `out_ready` is seen.
- **Single-sample frame:** a sample with `in_last` = 1 accepted in `IDLE` produces the result one cycle later. The result is min = max = sample, count = 1.
- **Throughput:** `in_ready` is 0 for every cycle in `HOLD`.
  - At minimum this is one bubble cycle per frame, when `out_ready` is held at 1.
  - No sample is ever accepted in the same cycle as a result handshake.
- **Backpressure:** while `out_ready` = 0, `HOLD` persists indefinitely with outputs frozen and `in_ready` = 0.
- **`in_valid` while `in_ready` = 0:** ignored. The source must hold the sample until `in_ready` is 1.
- **Reset mid-frame or in `HOLD`:** the partial frame is discarded, with no result emitted, and the block returns to reset values immediately.
- **Count saturation (CNT_WIDTH = 8):** the 255th sample gives count 255, sat = 0. The 256th and later samples keep count at 255 and set sat = 1. min and max keep tracking all samples.

## Test plan
- **Reset:** assert `Rst_n` = 0 mid-`ACC` after samples 5, 9 -> outputs all 0, `out_valid` = 0, `in_ready` = 1. Release, then send 7 with last -> min = 7, max = 7, count = 1.
- **Basic frame:** 30, 10, 50, 10, 50 (last) with `out_ready` = 1 -> one cycle after the last accept, `out_valid` = 1, min = 10, max = 50, count = 5, sat = 0. `in_ready` = 0 for exactly that cycle.
- **Unsigned extremes:** 8'h80, 8'hFF, 8'h00, 8'h7F (last) -> min = 8'h00, max = 8'hFF, count = 4.
- **Backpressure:** frame 3, 4 (last) with `out_ready` = 0 for 5 cycles -> `out_valid` stays 1 with min = 3, max = 4, count = 2 frozen. `in_valid` asserted with value 99 is not accepted. Raising `out_ready` -> `IDLE`, and a next frame of 99 (last) gives min = max = 99.
- **Saturation:** 300 samples of value i mod 256, last on the 300th -> count = 255, sat = 1, min = 0, max = 255. The next frame of 2 samples gives count = 2, sat = 0.
- **Back-to-back frames:** random frames of lengths 1–20 with random `in_valid`/`out_ready` gaps -> every result matches a reference model, and no frame is dropped or merged.
